// File: rtl/a_mcp_pkg.sv
// rtl/a_mcp_pkg.sv - shared state type and constants for the MCP sender arbiter
package a_mcp_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   localparam int DW       = 8;
   localparam int NREQ_DEF = 4;

endpackage

// File: rtl/a_rr_pick.sv
// rtl/a_rr_pick.sv - combinational round-robin winner search starting at ptr
module a_rr_pick
   import a_mcp_pkg::*;
#(
   parameter  int NREQ = NREQ_DEF,
   localparam int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_valid,
   input  logic [IW-1:0]   ptr,
   output logic [IW-1:0]   win,
   output logic            any_valid
);

   always_comb begin
      int idx;
      win       = '0;
      any_valid = 1'b0;
      idx       = 0;
      // walk NREQ slots from ptr with wrap; the first valid slot is latched
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         if (!any_valid && req_valid[IW'(idx)]) begin
            any_valid = 1'b1;
            win       = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/a_mcp_arbiter.sv
// rtl/a_mcp_arbiter.sv - round-robin arbiter feeding one MCP sender, one staged word
// Optional sender-stall timeout flag is built when A_MCP_ARB_TIMEOUT_EN is defined.
module a_mcp_arbiter
   import a_mcp_pkg::*;
#(
   parameter  int NREQ      = NREQ_DEF,
   parameter  int TO_CYCLES = 255,
   localparam int IW        = $clog2(NREQ)
) (
   input  logic                     aclk,
   input  logic                     arst,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ-1:0][DW-1:0]  req_data,
   output logic [NREQ-1:0]          req_ready,
   input  logic                     aready,
   output logic [DW-1:0]            adatain,
   output logic                     asend,
   output logic [IW-1:0]            a_gnt_id,
   output logic                     busy,
   output logic                     timeout_err
);

   state_t          state;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   win;
   logic            any_valid;
   logic            grant_en;
   logic [DW-1:0]   stage;

   a_rr_pick #(
      .NREQ (NREQ)
   ) u_pick (
      .req_valid (req_valid),
      .ptr       (ptr),
      .win       (win),
      .any_valid (any_valid)
   );

   // the winner is always a valid requester, so a grant is also the transfer
   assign grant_en = (state == IDLE) && any_valid && !arst;

   always_comb begin
      req_ready = '0;
      if (grant_en) begin
         req_ready[win] = 1'b1;
      end
   end

   assign adatain = stage;

   always_ff @(posedge aclk) begin
      if (arst) begin
         state    <= IDLE;
         ptr      <= '0;
         stage    <= '0;
         a_gnt_id <= '0;
         asend    <= 1'b0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_en) begin
                  stage    <= req_data[win];
                  a_gnt_id <= win;
                  ptr      <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
                  asend    <= 1'b1;
                  busy     <= 1'b1;
                  state    <= SEND;
               end
            end
            SEND: begin
               if (aready) begin
                  asend <= 1'b0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               asend <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef A_MCP_ARB_TIMEOUT_EN
   localparam int CW = ($clog2(TO_CYCLES + 1) > 8) ? $clog2(TO_CYCLES + 1) : 8;

   logic [CW-1:0] to_cnt;

   // held at zero in IDLE so every SEND starts counting fresh; saturates at the limit
   always_ff @(posedge aclk) begin
      if (arst) begin
         to_cnt      <= '0;
         timeout_err <= 1'b0;
      end else if (state == IDLE) begin
         to_cnt <= '0;
      end else if (!aready && (to_cnt != CW'(TO_CYCLES))) begin
         to_cnt <= to_cnt + 1'b1;
         if (to_cnt == CW'(TO_CYCLES - 1)) begin
            timeout_err <= 1'b1;
         end
      end
   end
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_a_mcp_arbiter.sv
// tb/tb_a_mcp_arbiter.sv - self-checking bench for a_mcp_arbiter
module tb_a_mcp_arbiter;

   localparam int NREQ = 4;
   localparam int TO   = 10;
`ifdef A_MCP_ARB_TIMEOUT_EN
   localparam logic TO_ON = 1'b1;
`else
   localparam logic TO_ON = 1'b0;
`endif

   logic                   aclk;
   logic                   arst;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0][7:0]   req_data;
   logic [NREQ-1:0]        req_ready;
   logic                   aready;
   logic [7:0]             adatain;
   logic                   asend;
   logic [1:0]             a_gnt_id;
   logic                   busy;
   logic                   timeout_err;

   int total = 0;
   int bad   = 0;

   a_mcp_arbiter #(
      .NREQ      (NREQ),
      .TO_CYCLES (TO)
   ) dut (
      .aclk        (aclk),
      .arst        (arst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .aready      (aready),
      .adatain     (adatain),
      .asend       (asend),
      .a_gnt_id    (a_gnt_id),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // rotate the valid vector so ptr sits at bit 0, then take the lowest set bit
   function automatic int rr_first(input logic [NREQ-1:0] v, input int p);
      logic [2*NREQ-1:0] dbl;
      dbl = {v, v} >> p;
      for (int j = 0; j < NREQ; j++) begin
         if (dbl[j]) return (p + j) % NREQ;
      end
      return -1;
   endfunction

   bit         m_on   = 1'b0;
   bit         m_full = 1'b0;
   int         m_ptr  = 0;
   int         m_id   = 0;
   int         m_stall = 0;
   logic [7:0] m_data = '0;
   logic       m_err  = 1'b0;
   int         m_log[$];
   int         dut_log[$];

   always @(posedge aclk) begin
      if (arst) begin
         m_on = 1'b1; m_full = 1'b0; m_ptr = 0; m_id = 0;
         m_stall = 0; m_data = '0; m_err = 1'b0;
      end else if (m_on) begin
         if (!m_full) begin
            if (req_valid != '0) begin
               m_id    = rr_first(req_valid, m_ptr);
               m_data  = req_data[m_id];
               m_ptr   = (m_id + 1) % NREQ;
               m_full  = 1'b1;
               m_stall = 0;
               m_log.push_back(m_id);
            end
         end else if (aready) begin
            m_full = 1'b0;
         end else begin
            m_stall++;
            if (TO_ON && m_stall >= TO) m_err = 1'b1;
         end
      end
   end

   always @(negedge aclk) begin
      logic [NREQ-1:0] exp_rdy;
      if (m_on) begin
         exp_rdy = '0;
         if (!arst && !m_full && req_valid != '0) exp_rdy[rr_first(req_valid, m_ptr)] = 1'b1;
         chk("m_req_ready", 32'(req_ready), 32'(exp_rdy));
         chk("m_asend", 32'(asend), 32'(m_full));
         chk("m_busy", 32'(busy), 32'(m_full));
         chk("m_adatain", 32'(adatain), 32'(m_data));
         chk("m_gnt_id", 32'(a_gnt_id), 32'(m_id));
         chk("m_timeout", 32'(timeout_err), 32'(m_err));
      end
   end

   task automatic cyc();
      @(posedge aclk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge aclk);
   endtask

   task automatic do_reset();
      arst = 1'b1;
      cyc();
      arst = 1'b0;
   endtask

   int exp_order[5] = '{0, 1, 2, 3, 0};

   initial begin
      arst = 1'b1; req_valid = 4'b1111; req_data = '0; aready = 1'b1;
      cyc();
      cyc();
      at_neg();
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_asend", 32'(asend), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_gnt", 32'(a_gnt_id), 32'h0);
      chk("rst_data", 32'(adatain), 32'h0);
      chk("rst_timeout", 32'(timeout_err), 32'h0);

      // single request from requester 2
      cyc();
      arst = 1'b0; req_valid = 4'b0100; req_data = '0; req_data[2] = 8'h5A;
      at_neg();
      chk("single_ready", 32'(req_ready), 32'h4);
      cyc();
      req_valid = '0;
      at_neg();
      chk("single_asend", 32'(asend), 32'h1);
      chk("single_data", 32'(adatain), 32'h5A);
      chk("single_gnt", 32'(a_gnt_id), 32'h2);
      cyc();
      at_neg();
      chk("single_idle", 32'(asend), 32'h0);
      chk("single_hold", 32'(adatain), 32'h5A);

      // all four requesters continuously valid
      cyc();
      do_reset();
      for (int i = 0; i < NREQ; i++) req_data[i] = 8'hA0 + 8'(i);
      req_valid = 4'b1111;
      m_log.delete();
      dut_log.delete();
      for (int c = 0; c < 10; c++) begin
         at_neg();
         if (asend && aready) dut_log.push_back(int'(a_gnt_id));
         cyc();
      end
      req_valid = '0;
      chk("rr_dut_count", 32'(dut_log.size()), 32'd5);
      chk("rr_mdl_count", 32'(m_log.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < dut_log.size()) chk("rr_dut_order", 32'(dut_log[i]), 32'(exp_order[i]));
         if (i < m_log.size()) chk("rr_mdl_order", 32'(m_log[i]), 32'(exp_order[i]));
      end

      // stalled sender, requester 1 word 0x33
      req_valid = 4'b0010; req_data[1] = 8'h33; aready = 1'b0;
      at_neg();
      chk("stall_ready", 32'(req_ready), 32'h2);
      cyc();
      req_valid = '0;
      for (int c = 0; c < 20; c++) begin
         at_neg();
         chk("stall_hold", 32'({asend, adatain}), 32'h133);
         cyc();
      end
      aready = 1'b1;
      at_neg();
      chk("stall_last", 32'({asend, adatain}), 32'h133);
      cyc();
      at_neg();
      chk("stall_done", 32'(asend), 32'h0);

      // reset while a word waits in SEND
      cyc();
      req_valid = 4'b0100; req_data[2] = 8'h44; aready = 1'b0;
      cyc();
      req_valid = '0;
      at_neg();
      chk("mid_asend", 32'(asend), 32'h1);
      cyc();
      arst = 1'b1;
      at_neg();
      chk("mid_rst_ready", 32'(req_ready), 32'h0);
      cyc();
      arst = 1'b0; req_valid = 4'b1010; req_data[1] = 8'h11; req_data[3] = 8'h99;
      at_neg();
      chk("mid_post_asend", 32'(asend), 32'h0);
      chk("mid_post_busy", 32'(busy), 32'h0);
      chk("mid_post_ready", 32'(req_ready), 32'h2);
      cyc();
      req_valid = 4'b1000;
      at_neg();
      chk("mid_gnt", 32'(a_gnt_id), 32'h1);
      chk("mid_data", 32'(adatain), 32'h11);
      cyc();
      aready = 1'b1;
      cyc();
      at_neg();
      chk("mid_next_ready", 32'(req_ready), 32'h8);
      cyc();
      req_valid = '0;
      at_neg();
      chk("mid_next_gnt", 32'(a_gnt_id), 32'h3);
      chk("mid_next_data", 32'(adatain), 32'h99);

      // sender stall long enough to trip the timeout when it is built in
      cyc();
      do_reset();
      req_valid = 4'b0001; req_data[0] = 8'h77; aready = 1'b0;
      cyc();
      req_valid = '0;
      for (int k = 1; k <= 12; k++) begin
         cyc();
         at_neg();
         if (k == 9) chk("to_before", 32'(timeout_err), 32'h0);
         if (k == 10) chk("to_at_limit", 32'(timeout_err), 32'(TO_ON));
      end
      cyc();
      aready = 1'b1;
      at_neg();
      chk("to_send", 32'({asend, adatain}), 32'h177);
      cyc();
      at_neg();
      chk("to_done", 32'(asend), 32'h0);
      chk("to_sticky", 32'(timeout_err), 32'(TO_ON));
      cyc();
      do_reset();
      at_neg();
      chk("to_cleared", 32'(timeout_err), 32'h0);

      cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/a_mcp_arbiter.md
A_MCP_ARBITER -- requirements
Module: a_mcp_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of requesters sharing the MCP sender (2..8).
REQ-002 Parameter: TO_CYCLES, 255, aready-low wait limit before timeout_err is flagged (used only under A_MCP_ARB_TIMEOUT_EN).
REQ-003 aclk  in  1  single clock; everything in this block is synchronous to rising aclk.
REQ-004 arst  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  NREQ  per-requester word-valid.
REQ-006 req_data  in  NREQ x 8  per-requester data word.
REQ-007 req_ready  out  NREQ  per-requester accept; one-hot or zero.
REQ-008 aready  in  1  MCP sender ready for the next word.
REQ-009 adatain  out  8  data word presented to the MCP sender.
REQ-010 asend  out  1  send request to the MCP sender.
REQ-011 a_gnt_id  out  $clog2(NREQ)  index of the requester whose word is staged.
REQ-012 busy  out  1  high while in SEND.
REQ-013 timeout_err  out  1  sticky sender-stall flag.

Function
REQ-014 FSM states: IDLE, SEND.
REQ-015 IDLE: if any req_valid is set, req_ready[w] = 1 combinationally for the round-robin winner w; all other req_ready bits = 0.
REQ-016 Transfer: req_valid[w] & req_ready[w] on an edge loads stage <= req_data[w], a_gnt_id <= w, ptr <= (w+1) mod NREQ, and moves IDLE -> SEND.
REQ-017 Round robin: search starts at ptr and increments with wrap; the first requester with req_valid set wins.
REQ-018 IDLE with no req_valid: stay in IDLE; req_ready = 0; ptr unchanged.
REQ-019 SEND: asend = 1, adatain = stage, req_ready = 0.
REQ-020 SEND stays SEND, holding stage, until asend & aready is sampled; that edge moves SEND -> IDLE.
REQ-021 IDLE: asend = 0; adatain holds the last staged value.
REQ-022 Latency: req_valid in IDLE -> asend high on the next cycle; each word is sent exactly once.
REQ-023 Pipelining: IDLE may grant the next word while the sender still has aready low; that word then waits in SEND.
REQ-024 Requesters keep req_valid and req_data stable until accepted; the arbiter never drops an accepted word.
REQ-025 Simultaneous requests: exactly one grant per IDLE cycle, chosen per REQ-017.

Reset
REQ-026 arst = 1 at an edge forces state = IDLE, ptr = 0, stage = 0, a_gnt_id = 0, timeout_err = 0, and clears the timeout counter.
REQ-027 Outputs during and after reset: asend = 0, busy = 0, req_ready = 0 while arst = 1.
REQ-028 Reset mid-SEND discards the staged word; no asend appears in the cycle after reset.

Configuration
REQ-029 With A_MCP_ARB_TIMEOUT_EN defined:
- an 8-bit-or-wider counter clears on entry to SEND;
- it increments on each SEND cycle with aready = 0;
- when it reaches TO_CYCLES, timeout_err is set to 1 and stays 1 until arst;
- the FSM keeps waiting and the word is not dropped.
REQ-030 Without A_MCP_ARB_TIMEOUT_EN: timeout_err is tied to 0 and no counter is present.

Structure
REQ-031 Package a_mcp_pkg holds:
- the state enum typedef (IDLE, SEND);
- the DW = 8 constant;
- the NREQ default.
REQ-032 One sub-module, a_rr_pick, is combinational; it takes req_valid and ptr and returns the winner index plus an any-valid flag.

Verification
REQ-033 Single request: req_valid = 4'b0100, data 0x5A, aready = 1 -> req_ready = 4'b0100 in cycle 0; asend = 1 with adatain = 0x5A in cycle 1; back to IDLE in cycle 2; a_gnt_id = 2.
REQ-034 All four requesters valid continuously, aready always 1 -> grant order 0,1,2,3,0; one word per 2 cycles.
REQ-035 Stalled sender: aready = 0 for 20 cycles during SEND -> asend and adatain (0x33) stay stable; transfer completes on the first aready = 1.
REQ-036 Reset mid-SEND: arst = 1 for 1 cycle -> asend = 0, busy = 0, ptr = 0; the next grant goes to the lowest valid index.
REQ-037 Timeout (macro on, TO_CYCLES = 10): aready held 0 -> timeout_err rises after 10 stalled cycles and stays 1 after aready returns; the word is still sent.
REQ-038 Macro off, same stimulus as REQ-037 -> timeout_err stays 0 throughout.
